// File: rtl/cnt_mod_updn.sv
// ---------------------------------------------------------------------------
// cnt_mod_updn
//
// Parametrised modulo up/down counter with a runtime terminal value. The count
// range is 0..lim. Three run modes are supported:
//   wrap     : at the terminal value the count restarts from the other end and
//              a one-cycle registered wrap pulse follows.
//   saturate : at the terminal value the count holds.
//   one-shot : at the terminal value the count holds and the counter enters
//              DONE, where it stays frozen until the next load or reset.
// Several instances cascade by feeding tc of a low stage into ce of the next.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high (cnt=RST_VAL, wrap=0, done=0)
//   pe   - parallel load enable; loads min(d, lim), clears done
//   ce   - count enable
//   up   - direction, 1 = increment, 0 = decrement
//   mode - 00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap
//   d    - parallel load value
//   lim  - terminal value
//   cnt  - registered count
//   tc   - combinational terminal count (cascade enable for the next stage)
//   wrap - registered pulse, high the cycle after a wrap event
//   done - registered, high while the one-shot FSM sits in DONE
//
// Handshake: none. ce is a plain enable sampled on every rising edge; tc is
// valid in the same cycle as the ce that produces it and needs no ready.
// ---------------------------------------------------------------------------
module cnt_mod_updn #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pe,
    input  logic             ce,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [1:0]       MODE_SAT = 2'b01;
    localparam logic [1:0]       MODE_ONE = 2'b10;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             at_term;

    // Counting up, anything at or above lim is terminal, so lowering lim
    // below the current count forces the terminal action on the next edge.
    assign at_term = up ? (cnt >= lim) : (cnt == '0);

    // The FSM state is directly observable: done is the state register.
    assign done = (state == DONE);
    assign tc   = ce & at_term & ~pe & ~done;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        if (pe) begin
            cnt_nxt   = (d > lim) ? lim : d;
            state_nxt = RUN;
        end else if (ce && (state == RUN)) begin
            if (!at_term) begin
                cnt_nxt = up ? (cnt + ONE) : (cnt - ONE);
            end else begin
                case (mode)
                    MODE_SAT: begin
                        cnt_nxt = cnt;
                    end
                    MODE_ONE: begin
                        state_nxt = DONE;
                    end
                    default: begin
                        cnt_nxt  = up ? '0 : lim;
                        wrap_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= RST_VAL;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: doc/cnt_mod_updn.md
Name: cnt_mod_updn

Overview:
- Parametrised successor to the team's loadable 3-bit up counter.
- Generic WIDTH with a runtime terminal value `lim`, so the count range is 0..lim.
- Adds up/down direction, three run modes (wrap, saturate, one-shot), a cascade terminal-count output, a registered wrap pulse and a one-shot done flag.
- Intended for timers, clock dividers and modulo sequencers in the lab designs; multiple instances cascade via tc -> ce.

Parameters:
WIDTH, 8, counter and data width in bits (>=2)
RST_VAL, 0, value loaded into cnt on reset (must be <= any lim used)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
pe  in  1  parallel load enable (highest priority after rst)
ce  in  1  count enable
up  in  1  direction: 1 = increment, 0 = decrement
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
d  in  WIDTH  parallel load value
lim  in  WIDTH  terminal value; count range is 0..lim
cnt  out  WIDTH  registered count
tc  out  1  combinational terminal count: ce & at_term & ~pe & ~done
wrap  out  1  registered one-cycle pulse, one cycle after a wrap event
done  out  1  registered; one-shot completed

Behaviour:
- Single clock domain. All state updates on rising clk edge.
- Reset is synchronous, active-high. When rst=1 at an edge: cnt=RST_VAL, wrap=0, done=0, FSM=RUN.
- Priority each edge: rst > pe > ce > hold.
- at_term definition:
  - up=1: at_term = (cnt >= lim).
  - up=0: at_term = (cnt == 0).
- Load (pe=1):
  - cnt = min(d, lim), i.e. d is clamped to lim.
  - done is cleared and FSM returns to RUN. wrap=0.
  - ce is ignored in that cycle.
- Count (pe=0, ce=1, FSM=RUN):
  - Not at_term: cnt = cnt+1 if up, else cnt-1. Width stays WIDTH; no overflow is possible inside 0..lim.
  - At terminal, wrap mode: up -> cnt=0; down -> cnt=lim. wrap=1 the next cycle.
  - At terminal, saturate mode: cnt holds. wrap stays 0.
  - At terminal, one-shot mode: cnt holds, FSM -> DONE, done=1 from the next cycle.
- FSM states:
  - RUN: counts per the rules above.
  - DONE: cnt frozen regardless of ce/up/mode, done=1, tc=0.
  - DONE exits only on pe or rst.
  - A mode change while in DONE does not leave DONE.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (lim=0, ce held) keep wrap high continuously.
- lim lowered below cnt while counting up: cnt>=lim counts as terminal, so the next enabled edge wraps to 0 (wrap), holds (saturate) or stops (one-shot). Direction down is unaffected until cnt reaches 0.
- lim=0: cnt stays 0. tc=ce each cycle. Wrap mode pulses wrap every enabled cycle.
- up may change every cycle; direction takes effect on the same edge.
- mode changes take effect on the next enabled edge.
- Asserting rst mid-count or in DONE overrides everything in that cycle.
- tc has no register delay. It is the cascade enable for the next stage: high-order ce = tc of the low-order stage.

Test Plan:
- Reset/load: rst=1 one edge -> cnt=0, wrap=0, done=0. Then pe=1, d=8'd200, lim=8'd150 -> cnt=150. Same edge with ce=1 -> still 150 (pe wins).
- Wrap up/down: WIDTH=8, lim=9, mode=00, up=1, ce=1 from cnt=0.
  - After 9 edges cnt=9 and tc=1; next edge cnt=0, with wrap=1 for one cycle.
  - With up=0 from 0: next edge cnt=9, wrap pulse.
- Saturate: lim=5, mode=01, up=1, ce held 10 cycles -> cnt sticks at 5, wrap never asserts. With up=0 from 2: stick at 0, tc=1 while ce=1.
- One-shot: lim=3, mode=10, from cnt=0, ce held -> cnt 1,2,3. done=1 on the edge after cnt=3, cnt frozen at 3, tc=0. Then pe=1, d=1 -> cnt=1, done=0, counting resumes.
- Boundaries:
  - lim changed from 20 to 4 while cnt=10 and counting up in wrap mode -> next edge cnt=0 with wrap pulse.
  - lim=0 in wrap mode with ce held -> cnt=0 and wrap=1 continuously.
  - rst asserted in DONE -> cnt=RST_VAL, done=0.
- Cascade: two WIDTH=4 instances, lim=15, low-stage tc driving high-stage ce -> combined count runs 0..255 and wraps to 0 after 256 edges.
